// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizing for the register-file scoreboard.
package reg_scoreboard_pkg;

   localparam int unsigned REG_ADDR_W      = 5;
   localparam int unsigned N_REG           = 32;
   localparam int unsigned MAX_OUTSTANDING = 4;
   localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1);

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [N_REG-1:0]      reg_vec_t;
   typedef logic [CNT_W-1:0]      cnt_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   // One-hot decode of a register address; register zero never maps to a bit.
   function automatic reg_vec_t reg_onehot(input reg_addr_t a);
      reg_vec_t v;
      v = '0;
      if (a != REG_ZERO) v[a] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-issue and long-latency writeback bus seen by the scoreboard.
//   master: decode/writeback side, drives issue_* and wb_*, reads issue_stall
//   slave : scoreboard, reads issue_* and wb_*, drives issue_stall
interface reg_scoreboard_if;
   import reg_scoreboard_pkg::*;

   logic      issue_valid;
   reg_addr_t issue_rs1;
   logic      issue_use_rs1;
   reg_addr_t issue_rs2;
   logic      issue_use_rs2;
   reg_addr_t issue_rd;
   logic      issue_long;
   logic      issue_stall;
   logic      wb_valid;
   reg_addr_t wb_rd;

   modport master (
      output issue_valid, issue_rs1, issue_use_rs1, issue_rs2, issue_use_rs2,
             issue_rd, issue_long, wb_valid, wb_rd,
      input  issue_stall
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_use_rs1, issue_rs2, issue_use_rs2,
             issue_rd, issue_long, wb_valid, wb_rd,
      output issue_stall
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency producers; raises the decode
// stall on RAW/WAW hazards and when the in-flight limit is reached.
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : issue request, writeback, combinational issue_stall
//   busy_vec_o       : registered pending-write bit per register
//   outstanding_o    : registered count of long writes in flight
//   err_spurious_o   : sticky flag, writeback to a non-busy register
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   reg_scoreboard_if.slave    bus,
   output reg_vec_t           busy_vec_o,
   output cnt_t               outstanding_o,
   output logic               err_spurious_o
);

   reg_vec_t busy_q, busy_d;
   cnt_t     cnt_q, cnt_d;
   logic     err_q, err_d;

   reg_vec_t wb_clr;
   reg_vec_t eff_busy;
   logic     wb_dec;
   logic     wb_spurious;
   logic     raw1, raw2, waw, full;
   logic     fire;

   // Writeback clear; the register file bypass makes it visible this cycle.
   always_comb begin
      wb_clr      = bus.wb_valid ? reg_onehot(bus.wb_rd) : '0;
      eff_busy    = busy_q & ~wb_clr;
      // Only a clear of a genuinely busy register retires an in-flight write.
      wb_dec      = |(wb_clr & busy_q);
      wb_spurious = bus.wb_valid && (bus.wb_rd != REG_ZERO) && !busy_q[bus.wb_rd];
   end

   // Hazard detection and stall.
   always_comb begin
      raw1 = bus.issue_use_rs1 && (bus.issue_rs1 != REG_ZERO) && eff_busy[bus.issue_rs1];
      raw2 = bus.issue_use_rs2 && (bus.issue_rs2 != REG_ZERO) && eff_busy[bus.issue_rs2];
      waw  = (bus.issue_rd != REG_ZERO) && eff_busy[bus.issue_rd];
      full = bus.issue_long && (bus.issue_rd != REG_ZERO) &&
             ((cnt_q - CNT_W'(wb_dec)) == CNT_W'(MAX_OUTSTANDING));
      bus.issue_stall = rst || (bus.issue_valid && (raw1 || raw2 || waw || full));
      fire = bus.issue_valid && !bus.issue_stall && bus.issue_long &&
             (bus.issue_rd != REG_ZERO);
   end

   // Next state; a same-cycle clear and set of one register leaves it busy.
   always_comb begin
      busy_d = eff_busy | (fire ? reg_onehot(bus.issue_rd) : '0);
      cnt_d  = cnt_q - CNT_W'(wb_dec) + CNT_W'(fire);
      err_d  = err_q | wb_spurious;
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign busy_vec_o     = busy_q;
   assign outstanding_o  = cnt_q;
   assign err_spurious_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   logic     clk;
   logic     rst;
   reg_vec_t busy_vec;
   cnt_t     outstanding;
   logic     err_spurious;
   int       passed;
   int       total;

   reg_scoreboard_if bus ();

   reg_scoreboard dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus.slave),
      .busy_vec_o     (busy_vec),
      .outstanding_o  (outstanding),
      .err_spurious_o (err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle();
      bus.issue_valid   = 1'b0;
      bus.issue_rs1     = '0;
      bus.issue_use_rs1 = 1'b0;
      bus.issue_rs2     = '0;
      bus.issue_use_rs2 = 1'b0;
      bus.issue_rd      = '0;
      bus.issue_long    = 1'b0;
      bus.wb_valid      = 1'b0;
      bus.wb_rd         = '0;
   endtask

   task automatic issue(input logic lng, input reg_addr_t rd,
                        input logic u1, input reg_addr_t r1,
                        input logic u2, input reg_addr_t r2);
      bus.issue_valid   = 1'b1;
      bus.issue_long    = lng;
      bus.issue_rd      = rd;
      bus.issue_use_rs1 = u1;
      bus.issue_rs1     = r1;
      bus.issue_use_rs2 = u2;
      bus.issue_rs2     = r2;
   endtask

   task automatic wb(input reg_addr_t rd);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = rd;
   endtask

   // Let combinational outputs settle, then advance one clock.
   task automatic settle();
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      idle();
      rst = 1'b1;
      settle();
      chk("stall_in_reset", 32'(bus.issue_stall), 32'd1);
      tick();
      chk("rst_busy", 32'(busy_vec), 32'd0);
      chk("rst_out",  32'(outstanding), 32'd0);
      chk("rst_err",  32'(err_spurious), 32'd0);
      rst = 1'b0;

      // Long rd=5 then dependent read.
      issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0); settle();
      chk("long5_stall", 32'(bus.issue_stall), 32'd0);
      tick();
      chk("long5_busy", 32'(busy_vec), 32'h0000_0020);
      chk("long5_out",  32'(outstanding), 32'd1);
      issue(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0); settle();
      chk("raw1_stall", 32'(bus.issue_stall), 32'd1);
      bus.issue_valid = 1'b0; settle();
      chk("raw1_novalid", 32'(bus.issue_stall), 32'd0);
      bus.issue_valid = 1'b1;
      wb(5'd5); settle();
      chk("raw1_wb_bypass", 32'(bus.issue_stall), 32'd0);
      tick(); idle();
      chk("wb5_busy", 32'(busy_vec), 32'd0);
      chk("wb5_out",  32'(outstanding), 32'd0);

      // Register zero is never busy.
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0); settle();
      chk("rd0_stall", 32'(bus.issue_stall), 32'd0);
      tick();
      chk("rd0_busy", 32'(busy_vec), 32'd0);
      chk("rd0_out",  32'(outstanding), 32'd0);
      issue(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0); settle();
      chk("rs0_stall", 32'(bus.issue_stall), 32'd0);
      tick(); idle();

      // Fill to the in-flight limit.
      for (int i = 1; i <= 4; i++) begin
         issue(1'b1, reg_addr_t'(i), 1'b0, 5'd0, 1'b0, 5'd0); settle();
         chk("fill_stall", 32'(bus.issue_stall), 32'd0);
         tick();
      end
      chk("fill_out",  32'(outstanding), 32'd4);
      chk("fill_busy", 32'(busy_vec), 32'h0000_001E);
      issue(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0); settle();
      chk("full_stall", 32'(bus.issue_stall), 32'd1);
      tick();
      chk("full_out_hold", 32'(outstanding), 32'd4);
      wb(5'd1); settle();
      chk("full_wb_stall", 32'(bus.issue_stall), 32'd0);
      tick(); idle();
      chk("full_wb_out",  32'(outstanding), 32'd4);
      chk("full_wb_busy", 32'(busy_vec), 32'h0000_005C);
      wb(5'd2); tick(); wb(5'd3); tick(); wb(5'd4); tick(); wb(5'd6); tick(); idle();
      chk("drain_busy", 32'(busy_vec), 32'd0);
      chk("drain_out",  32'(outstanding), 32'd0);

      // Same-cycle clear and re-issue of r7.
      issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0); tick();
      chk("r7_out", 32'(outstanding), 32'd1);
      wb(5'd7); settle();
      chk("r7_reissue_stall", 32'(bus.issue_stall), 32'd0);
      tick(); idle();
      chk("r7_busy", 32'(busy_vec), 32'h0000_0080);
      chk("r7_out_same", 32'(outstanding), 32'd1);

      // WAW on r9 from a short write, plus rs2 RAW.
      issue(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0); tick();
      chk("r9_busy", 32'(busy_vec), 32'h0000_0280);
      chk("r9_out",  32'(outstanding), 32'd2);
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9); settle();
      chk("raw2_stall", 32'(bus.issue_stall), 32'd1);
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9); settle();
      chk("raw2_unused", 32'(bus.issue_stall), 32'd0);
      issue(1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0); settle();
      chk("waw_stall", 32'(bus.issue_stall), 32'd1);
      tick();
      chk("waw_stall_hold", 32'(bus.issue_stall), 32'd1);
      wb(5'd9); settle();
      chk("waw_release", 32'(bus.issue_stall), 32'd0);
      tick(); idle();
      chk("waw_busy", 32'(busy_vec), 32'h0000_0080);
      chk("waw_out",  32'(outstanding), 32'd1);
      wb(5'd7); tick(); idle();
      chk("r7_clear_out", 32'(outstanding), 32'd0);

      // Writeback to r0 is ignored; to a non-busy register it is spurious.
      wb(5'd0); tick(); idle();
      chk("wb0_err", 32'(err_spurious), 32'd0);
      wb(5'd12); tick(); idle();
      chk("spur_err",  32'(err_spurious), 32'd1);
      chk("spur_busy", 32'(busy_vec), 32'd0);
      chk("spur_out",  32'(outstanding), 32'd0);
      tick();
      chk("spur_sticky", 32'(err_spurious), 32'd1);

      // Reset mid-operation discards pending state.
      issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0); tick(); idle();
      chk("pre_rst_busy", 32'(busy_vec), 32'h0000_0008);
      rst = 1'b1; settle();
      chk("rst2_stall", 32'(bus.issue_stall), 32'd1);
      tick();
      chk("rst2_busy", 32'(busy_vec), 32'd0);
      chk("rst2_out",  32'(outstanding), 32'd0);
      chk("rst2_err",  32'(err_spurious), 32'd0);
      rst = 1'b0; settle();
      chk("post_rst_stall", 32'(bus.issue_stall), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
